button_debounce: RTL and testbench

- Conditions raw board push-button inputs before they reach downstream gate logic, such as the LED AND gate driven by BTNU/BTNR.
- Per channel, it:
  - synchronises the asynchronous pad signal into CLK;
  - rejects mechanical bounce with a stable-time counter FSM;
  - emits a clean level plus one-cycle press/release pulses.
- Sits directly between the board button pins and the combinational gate stage.

---
 rtl/button_debounce_pkg.sv | 25 ++
 rtl/button_debounce_channel.sv | 110 +++++++++++
 rtl/button_debounce.sv | 38 +++
 tb/tb_button_debounce.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// Shared definitions for the push-button debouncer: channel FSM state
// encoding, a constant-foldable clog2 helper and the board default for a
// 10 ms stable time at 100 MHz.
package button_debounce_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_10MS = 1000000;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } btn_state_t;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (((v - 1) >> i) != 0) r = int'(i) + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// Single-bit debouncer: SYNC_STAGES-deep synchroniser, stable-time counter
// and a four-state FSM producing a registered level plus press/release pulses.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_btn             raw asynchronous pad
//   o_level           debounced level
//   o_press/o_release one-cycle pulses on accepted 0->1 / 1->0 transitions
module button_debounce_channel
  import button_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES_10MS
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int unsigned CNT_W = clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  btn_state_t             r_state;
  btn_state_t             w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_press;
  logic                   w_release;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Synchroniser chain; only the last stage is visible to the FSM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
  end

  // State, counter and registered outputs. Level and pulses are taken from
  // the next state so they change on the same edge as the FSM transition.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_LOW;
      r_cnt     <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      o_level   <= (w_state_nxt == S_HIGH) || (w_state_nxt == S_WAIT_LOW);
      o_press   <= w_press;
      o_release <= w_release;
    end
  end

  // Next-state logic; the counter is cleared on every state entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      S_LOW: begin
        if (w_sync) begin
          w_state_nxt = S_WAIT_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!w_sync) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
          w_press     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!w_sync) begin
          w_state_nxt = S_WAIT_LOW;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT_LOW: begin
        if (w_sync) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
          w_release   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button conditioner placed between the board pads and
// the downstream gate logic. Each bit is debounced independently.
// Ports:
//   CLK, RST     clock, asynchronous active-high reset
//   BTN_IN       raw bouncing pads
//   BTN_OUT      debounced levels
//   BTN_PRESS    one-cycle pulse per accepted 0->1 transition
//   BTN_RELEASE  one-cycle pulse per accepted 1->0 transition
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned NUM_BTN       = 2,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES_10MS
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_BTN-1:0] BTN_IN,
  output logic [NUM_BTN-1:0] BTN_OUT,
  output logic [NUM_BTN-1:0] BTN_PRESS,
  output logic [NUM_BTN-1:0] BTN_RELEASE
);

  for (genvar g = 0; g < int'(NUM_BTN); g++) begin : g_ch
    button_debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .i_clk    (CLK),
      .i_rst    (RST),
      .i_btn    (BTN_IN[g]),
      .o_level  (BTN_OUT[g]),
      .o_press  (BTN_PRESS[g]),
      .o_release(BTN_RELEASE[g])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  localparam int unsigned STABLE  = 16;
  localparam int          LATENCY = 19;

  logic       CLK;
  logic       RST;
  logic [1:0] BTN_IN;
  logic [1:0] BTN_OUT;
  logic [1:0] BTN_PRESS;
  logic [1:0] BTN_RELEASE;

  int n_tests;
  int n_fail;

  // Reference model: input seen by each channel lags the pad by two edges;
  // the level flips once the seen value has differed from it for STABLE+1
  // consecutive edges (first differing edge starts the wait, STABLE more
  // confirm it).
  logic [1:0] m_d1, m_d2, m_lvl, m_press, m_rel;
  int         m_run [2];

  button_debounce #(
    .NUM_BTN      (2),
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BTN_IN     (BTN_IN),
    .BTN_OUT    (BTN_OUT),
    .BTN_PRESS  (BTN_PRESS),
    .BTN_RELEASE(BTN_RELEASE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
    m_run[0] = 0; m_run[1] = 0;
  endtask

  task automatic model_step(input logic [1:0] pad);
    for (int ch = 0; ch < 2; ch++) begin
      m_press[ch] = 1'b0;
      m_rel[ch]   = 1'b0;
      if (m_d2[ch] != m_lvl[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == int'(STABLE) + 1) begin
          m_lvl[ch] = ~m_lvl[ch];
          if (m_lvl[ch]) m_press[ch] = 1'b1;
          else           m_rel[ch]   = 1'b1;
          m_run[ch] = 0;
        end
      end else begin
        m_run[ch] = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = pad;
  endtask

  // One rising edge; returns at the following falling edge for sampling.
  task automatic tick();
    @(posedge CLK);
    model_step(BTN_IN);
    @(negedge CLK);
  endtask

  task automatic hold(input logic [1:0] v, input int n);
    BTN_IN = v;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    BTN_IN = 2'b00;
    model_reset();
    repeat (3) @(negedge CLK);
    n_tests++;
    if (BTN_OUT !== 2'b00) begin n_fail++; $display("FAIL reset_out got=%b exp=00", BTN_OUT); end
    n_tests++;
    if (BTN_PRESS !== 2'b00) begin n_fail++; $display("FAIL reset_press got=%b exp=00", BTN_PRESS); end
    n_tests++;
    if (BTN_RELEASE !== 2'b00) begin n_fail++; $display("FAIL reset_release got=%b exp=00", BTN_RELEASE); end
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_clean_press();
    int rise_edge, press_edge, presses;
    logic ch1_bad;
    rise_edge = 0; press_edge = 0; presses = 0; ch1_bad = 1'b0;
    BTN_IN = 2'b01;
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (BTN_PRESS[0]) begin presses++; press_edge = k; end
      if (BTN_OUT[0] && rise_edge == 0) rise_edge = k;
      if (BTN_OUT[1] || BTN_PRESS[1] || BTN_RELEASE[1]) ch1_bad = 1'b1;
    end
    n_tests++;
    if (rise_edge != LATENCY) begin n_fail++; $display("FAIL clean_rise_edge got=%0d exp=%0d", rise_edge, LATENCY); end
    n_tests++;
    if (presses != 1 || press_edge != LATENCY) begin
      n_fail++; $display("FAIL clean_press got=%0d@%0d exp=1@%0d", presses, press_edge, LATENCY);
    end
    n_tests++;
    if (ch1_bad !== 1'b0) begin n_fail++; $display("FAIL clean_ch1_quiet got=%b exp=0", ch1_bad); end
    hold(2'b00, 26);
    n_tests++;
    if (BTN_OUT !== m_lvl) begin n_fail++; $display("FAIL clean_back_low got=%b exp=%b", BTN_OUT, m_lvl); end
  endtask

  task automatic test_bounce();
    int runs [4];
    int rise_edge, presses;
    logic early;
    runs[0] = 3; runs[1] = 5; runs[2] = 2; runs[3] = 7;
    early = 1'b0; rise_edge = 0; presses = 0;
    for (int r = 0; r < 4; r++) begin
      BTN_IN[0] = (r % 2 == 0);
      for (int k = 0; k < runs[r]; k++) begin
        tick();
        if (BTN_OUT[0] || BTN_PRESS[0]) early = 1'b1;
      end
    end
    BTN_IN[0] = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (BTN_PRESS[0]) presses++;
      if (BTN_OUT[0] && rise_edge == 0) rise_edge = k;
      if (k < LATENCY && BTN_OUT[0]) early = 1'b1;
    end
    n_tests++;
    if (early !== 1'b0) begin n_fail++; $display("FAIL bounce_no_early got=%b exp=0", early); end
    n_tests++;
    if (rise_edge != LATENCY) begin n_fail++; $display("FAIL bounce_rise_edge got=%0d exp=%0d", rise_edge, LATENCY); end
    n_tests++;
    if (presses != 1) begin n_fail++; $display("FAIL bounce_press_count got=%0d exp=1", presses); end
  endtask

  task automatic test_release_glitch();
    int fall_edge, rels;
    logic glitch_bad;
    glitch_bad = 1'b0; fall_edge = 0; rels = 0;
    BTN_IN[0] = 1'b0;
    repeat (10) begin tick(); if (BTN_RELEASE[0] || !BTN_OUT[0]) glitch_bad = 1'b1; end
    BTN_IN[0] = 1'b1;
    repeat (3) begin tick(); if (BTN_RELEASE[0] || !BTN_OUT[0]) glitch_bad = 1'b1; end
    BTN_IN[0] = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (BTN_RELEASE[0]) rels++;
      if (!BTN_OUT[0] && fall_edge == 0) fall_edge = k;
    end
    n_tests++;
    if (glitch_bad !== 1'b0) begin n_fail++; $display("FAIL glitch_ignored got=%b exp=0", glitch_bad); end
    n_tests++;
    if (fall_edge != LATENCY) begin n_fail++; $display("FAIL release_edge got=%0d exp=%0d", fall_edge, LATENCY); end
    n_tests++;
    if (rels != 1) begin n_fail++; $display("FAIL release_count got=%0d exp=1", rels); end
  endtask

  task automatic test_simultaneous();
    int e0, e1, e_and;
    logic [1:0] press_at;
    e0 = 0; e1 = 0; e_and = 0; press_at = 2'b00;
    BTN_IN = 2'b11;
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (BTN_OUT[0] && e0 == 0) e0 = k;
      if (BTN_OUT[1] && e1 == 0) e1 = k;
      if ((BTN_OUT[0] & BTN_OUT[1]) && e_and == 0) e_and = k;
      if (k == LATENCY) press_at = BTN_PRESS;
    end
    n_tests++;
    if (e0 != LATENCY || e1 != LATENCY) begin
      n_fail++; $display("FAIL simul_rise_edges got=%0d,%0d exp=%0d", e0, e1, LATENCY);
    end
    n_tests++;
    if (press_at !== 2'b11) begin n_fail++; $display("FAIL simul_press got=%b exp=11", press_at); end
    n_tests++;
    if (e_and != LATENCY) begin n_fail++; $display("FAIL simul_and_edge got=%0d exp=%0d", e_and, LATENCY); end
  endtask

  task automatic test_reset_mid_wait();
    int e0, e1;
    e0 = 0; e1 = 0;
    hold(2'b10, 26);
    BTN_IN = 2'b11;
    repeat (13) tick();
    n_tests++;
    if (BTN_OUT !== 2'b10) begin n_fail++; $display("FAIL midwait_pre got=%b exp=10", BTN_OUT); end
    #2;
    RST = 1'b1;
    #1;
    n_tests++;
    if (BTN_OUT !== 2'b00 || BTN_PRESS !== 2'b00 || BTN_RELEASE !== 2'b00) begin
      n_fail++;
      $display("FAIL midwait_async_clear got=%b/%b/%b exp=00/00/00", BTN_OUT, BTN_PRESS, BTN_RELEASE);
    end
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (BTN_OUT[0] && e0 == 0) e0 = k;
      if (BTN_OUT[1] && e1 == 0) e1 = k;
    end
    n_tests++;
    if (e0 != LATENCY || e1 != LATENCY) begin
      n_fail++; $display("FAIL midwait_reaccept got=%0d,%0d exp=%0d", e0, e1, LATENCY);
    end
  endtask

  task automatic test_long_hold();
    int presses, rels, bad, fall_edge;
    presses = 0; rels = 0; bad = 0; fall_edge = 0;
    hold(2'b00, 26);
    BTN_IN = 2'b10;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (BTN_PRESS[1]) presses++;
      if (BTN_RELEASE[1]) rels++;
      if (BTN_OUT[1] !== (k >= LATENCY)) bad++;
    end
    n_tests++;
    if (presses != 1 || rels != 0) begin
      n_fail++; $display("FAIL long_hold_pulses got=%0d/%0d exp=1/0", presses, rels);
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL long_hold_level got=%0d bad cycles exp=0", bad); end
    BTN_IN = 2'b00;
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (BTN_RELEASE[1]) rels++;
      if (!BTN_OUT[1] && fall_edge == 0) fall_edge = k;
    end
    n_tests++;
    if (fall_edge != LATENCY || rels != 1) begin
      n_fail++; $display("FAIL long_hold_release got=%0d/%0d exp=%0d/1", fall_edge, rels, LATENCY);
    end
  endtask

  task automatic test_random();
    int len [2];
    int errs;
    errs = 0;
    len[0] = 0; len[1] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (len[ch] == 0) begin
          BTN_IN[ch] = 1'($urandom_range(0, 1));
          len[ch] = int'($urandom_range(1, 26));
        end
        len[ch]--;
      end
      tick();
      n_tests++;
      if (BTN_OUT !== m_lvl || BTN_PRESS !== m_press || BTN_RELEASE !== m_rel) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL random_cycle%0d got=%b/%b/%b exp=%b/%b/%b", c,
                   BTN_OUT, BTN_PRESS, BTN_RELEASE, m_lvl, m_press, m_rel);
        errs++;
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    hold(2'b00, 26);
    test_simultaneous();
    test_reset_mid_wait();
    test_long_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
